qea_host_ctrl: RTL and testbench
================================

QEA_HOST_CTRL -- requirements
Module: qea_host_ctrl

Interface
- REQ-001 PE_NUM_WIDTH, 2, log2 of PE lane count; PE_NUM = 2**PE_NUM_WIDTH.
- REQ-002 DATA_WIDTH, 32, real or imag component width; amplitude width AW = 2*DATA_WIDTH, laid out {real, imag}.
- REQ-003 NUM_FRAC_BIT, 30, fixed-point fraction bits; amplitude 1.0 = 1<<NUM_FRAC_BIT.
- REQ-004 MAX_QBIT_WIDTH, 6, qubit-count field width.
- REQ-005 STATE_ADDR_WIDTH, 16, QEA state RAM address width.
- REQ-006 CTX_ADDR_WIDTH, 16, QEA context RAM address width; context word width is AW.
- REQ-007 clk  in  1  single clock; all logic on the rising edge.
- REQ-008 rst  in  1  synchronous, active-high reset.
- REQ-009 i_cmd_valid / o_cmd_ready  in/out  1  job command handshake.
- REQ-010 i_cmd_qbit_num  in  MAX_QBIT_WIDTH  qubit count n of the job.
- REQ-011 i_cmd_ins_num  in  CTX_ADDR_WIDTH+1  number of context words to load.
- REQ-012 i_ctx_valid / o_ctx_ready  in/out  1  context-word stream handshake.
- REQ-013 i_ctx_data  in  AW  context word.
- REQ-014 o_res_valid / i_res_ready  out/in  1  result-stream handshake.
- REQ-015 o_res_data  out  PE_NUM*AW  one state RAM row.
- REQ-016 o_res_last  out  1  marks the final result row.
- REQ-017 o_err  out  1  one-cycle pulse on a rejected command.
- REQ-018 o_cycle_count  out  32  QEA execution cycles of the last job.
- REQ-019 o_qea_ctx_we  out  1  drives QEA i_ctx_en and i_ctx_wea.
- REQ-020 o_qea_ctx_addr / o_qea_ctx_data  out  CTX_ADDR_WIDTH / AW  QEA context write port.
- REQ-021 o_qea_state_ena / o_qea_state_wea  out  1 / 1  QEA state port enable and write enable.
- REQ-022 o_qea_state_addra / o_qea_state_dina  out  STATE_ADDR_WIDTH / PE_NUM*AW  QEA state port address and data.
- REQ-023 o_qea_start / o_qea_qbit_num  out  1 / MAX_QBIT_WIDTH  QEA start pulse and qubit count.
- REQ-024 i_qea_complete / i_qea_state_dout  in  1 / PE_NUM*AW  QEA completion flag and state read data (latency 1).

Function
- REQ-025 FSM states SHALL be IDLE, LOAD_CTX, INIT_STATE, START, RUN, RD_REQ, RD_WAIT, RD_OUT.
- REQ-026 o_cmd_ready SHALL be 1 only in IDLE; a handshake latches n and ins_num and holds n on o_qea_qbit_num until the next accepted command.
- REQ-027 Rows R = 2**(n-PE_NUM_WIDTH); a command with n<=PE_NUM_WIDTH or n>STATE_ADDR_WIDTH+PE_NUM_WIDTH SHALL pulse o_err for 1 cycle and stay in IDLE.
- REQ-028 LOAD_CTX: o_ctx_ready=1; each ctx handshake SHALL write i_ctx_data to address k (k=0..ins_num-1) in the same cycle via o_qea_ctx_we=1; ins_num=0 skips LOAD_CTX.
- REQ-029 INIT_STATE SHALL write R rows, 1 per cycle, ena=wea=1, address 0..R-1; row 0 = real 1<<NUM_FRAC_BIT in the most-significant lane with all other bits 0; all other rows are 0.
- REQ-030 START SHALL assert o_qea_start for exactly 1 cycle, clear o_cycle_count, then enter RUN.
- REQ-031 RUN SHALL ignore i_qea_complete in its first cycle, increment o_cycle_count every cycle (saturating at 2**32-1), and exit to RD_REQ on the first sampled i_qea_complete=1, without counting that cycle.
- REQ-032 RD_REQ SHALL drive ena=1, wea=0 for 1 cycle; RD_WAIT SHALL capture i_qea_state_dout into o_res_data on the next cycle; RD_OUT SHALL hold o_res_valid=1 and data stable until i_res_ready.
- REQ-033 o_res_last SHALL be 1 with the row at address R-1; its handshake returns to IDLE; otherwise the address increments and the FSM returns to RD_REQ.
- REQ-034 Input handshakes outside their states SHALL be ignored; o_qea_* enables SHALL be 0 outside LOAD_CTX, INIT_STATE and RD_REQ.

Reset
- REQ-035 rst=1 at any clock edge, including mid-job, SHALL force IDLE and drive all outputs to 0 on the next cycle, except o_cmd_ready=1 and o_cycle_count, which holds its value.
- REQ-036 After reset, no QEA write or start SHALL occur until a new command is accepted.

Verification
- REQ-037 n=4, ins_num=3 with a QEA model completing 10 cycles after start -> 3 ctx writes at addresses 0..2, 4 state writes (row0 = 0x40000000_00000000 in the top lane), one start pulse, o_cycle_count=10, 4 result rows with last on row 3.
- REQ-038 n=2 and n=19 -> o_err pulse, no QEA activity, o_cmd_ready stays 1.
- REQ-039 i_ctx_valid toggling every other cycle -> writes only on handshake cycles; addresses contiguous.
- REQ-040 i_res_ready held 0 for 5 cycles on row 1 -> o_res_data stable and no new read issued until accepted.
- REQ-041 rst pulsed during RUN -> IDLE next cycle; a following n=3 job completes correctly.
- REQ-042 ins_num=0 -> INIT_STATE directly after the command; start issued once.

Source files
------------

// File: rtl/qea_host_ctrl.sv
// Host-side sequencer for the QEA: loads the context RAM, seeds the state RAM
// with |0...0>, starts the accelerator, times it and streams the final state out.
module qea_host_ctrl #(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_FRAC_BIT     = 30,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int CTX_ADDR_WIDTH   = 16
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            i_cmd_valid,
    output logic                                            o_cmd_ready,
    input  logic [MAX_QBIT_WIDTH-1:0]                       i_cmd_qbit_num,
    input  logic [CTX_ADDR_WIDTH:0]                         i_cmd_ins_num,
    input  logic                                            i_ctx_valid,
    output logic                                            o_ctx_ready,
    input  logic [2*DATA_WIDTH-1:0]                         i_ctx_data,
    output logic                                            o_res_valid,
    input  logic                                            i_res_ready,
    output logic [(2**PE_NUM_WIDTH)*2*DATA_WIDTH-1:0]       o_res_data,
    output logic                                            o_res_last,
    output logic                                            o_err,
    output logic [31:0]                                     o_cycle_count,
    output logic                                            o_qea_ctx_we,
    output logic [CTX_ADDR_WIDTH-1:0]                       o_qea_ctx_addr,
    output logic [2*DATA_WIDTH-1:0]                         o_qea_ctx_data,
    output logic                                            o_qea_state_ena,
    output logic                                            o_qea_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]                     o_qea_state_addra,
    output logic [(2**PE_NUM_WIDTH)*2*DATA_WIDTH-1:0]       o_qea_state_dina,
    output logic                                            o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]                       o_qea_qbit_num,
    input  logic                                            i_qea_complete,
    input  logic [(2**PE_NUM_WIDTH)*2*DATA_WIDTH-1:0]       i_qea_state_dout
);
    localparam int PE_NUM = 2 ** PE_NUM_WIDTH;
    localparam int AW     = 2 * DATA_WIDTH;
    localparam int PW     = PE_NUM * AW;
    localparam int CW     = CTX_ADDR_WIDTH + 1;
    // |0...0>: real part 1.0 in the most-significant lane of row 0
    localparam logic [PW-1:0] INIT_ROW = {{(PW-1){1'b0}}, 1'b1} << (PW - DATA_WIDTH + NUM_FRAC_BIT);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_CTX   = 3'd1,
        INIT_STATE = 3'd2,
        START      = 3'd3,
        RUN        = 3'd4,
        RD_REQ     = 3'd5,
        RD_WAIT    = 3'd6,
        RD_OUT     = 3'd7
    } state_e;

    state_e                      state_q, state_d;
    logic [MAX_QBIT_WIDTH-1:0]   qbit_q, qbit_d;
    logic [CW-1:0]               ins_q, ins_d;
    logic [CW-1:0]               ctx_cnt_q, ctx_cnt_d;
    logic [STATE_ADDR_WIDTH-1:0] last_row_q, last_row_d;
    logic [STATE_ADDR_WIDTH-1:0] row_q, row_d;
    logic                        run_first_q, run_first_d;
    logic                        err_q, err_d;
    logic [PW-1:0]               res_data_q, res_data_d;
    logic [31:0]                 cycle_q, cycle_d;
    logic                        qbit_ok_s;
    logic                        last_hit_s;

    assign qbit_ok_s  = (32'(i_cmd_qbit_num) > 32'(PE_NUM_WIDTH)) &&
                        (32'(i_cmd_qbit_num) <= 32'(STATE_ADDR_WIDTH + PE_NUM_WIDTH));
    assign last_hit_s = (row_q == last_row_q);

    assign o_res_data     = res_data_q;
    assign o_err          = err_q;
    assign o_cycle_count  = cycle_q;
    assign o_qea_qbit_num = qbit_q;

    // Next-state and handshake/RAM-port decode
    always_comb begin
        state_d           = state_q;
        qbit_d            = qbit_q;
        ins_d             = ins_q;
        ctx_cnt_d         = ctx_cnt_q;
        last_row_d        = last_row_q;
        row_d             = row_q;
        run_first_d       = run_first_q;
        err_d             = 1'b0;
        res_data_d        = res_data_q;
        cycle_d           = cycle_q;
        o_cmd_ready       = 1'b0;
        o_ctx_ready       = 1'b0;
        o_qea_ctx_we      = 1'b0;
        o_qea_ctx_addr    = {CTX_ADDR_WIDTH{1'b0}};
        o_qea_ctx_data    = {AW{1'b0}};
        o_qea_state_ena   = 1'b0;
        o_qea_state_wea   = 1'b0;
        o_qea_state_addra = {STATE_ADDR_WIDTH{1'b0}};
        o_qea_state_dina  = {PW{1'b0}};
        o_qea_start       = 1'b0;
        o_res_valid       = 1'b0;
        o_res_last        = 1'b0;
        case (state_q)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid && qbit_ok_s) begin
                    qbit_d     = i_cmd_qbit_num;
                    ins_d      = i_cmd_ins_num;
                    ctx_cnt_d  = {CW{1'b0}};
                    row_d      = {STATE_ADDR_WIDTH{1'b0}};
                    last_row_d = STATE_ADDR_WIDTH'((32'd1 << (32'(i_cmd_qbit_num) - 32'(PE_NUM_WIDTH))) - 32'd1);
                    state_d    = (i_cmd_ins_num == {CW{1'b0}}) ? INIT_STATE : LOAD_CTX;
                end else begin
                    err_d = i_cmd_valid;
                end
            end
            LOAD_CTX: begin
                o_ctx_ready    = 1'b1;
                o_qea_ctx_we   = i_ctx_valid;
                o_qea_ctx_addr = ctx_cnt_q[CTX_ADDR_WIDTH-1:0];
                o_qea_ctx_data = i_ctx_data;
                if (i_ctx_valid) begin
                    ctx_cnt_d = ctx_cnt_q + CW'(1);
                    state_d   = (ctx_cnt_q + CW'(1) == ins_q) ? INIT_STATE : LOAD_CTX;
                end else begin
                    state_d = LOAD_CTX;
                end
            end
            INIT_STATE: begin
                o_qea_state_ena   = 1'b1;
                o_qea_state_wea   = 1'b1;
                o_qea_state_addra = row_q;
                o_qea_state_dina  = (row_q == {STATE_ADDR_WIDTH{1'b0}}) ? INIT_ROW : {PW{1'b0}};
                if (last_hit_s) begin
                    row_d   = {STATE_ADDR_WIDTH{1'b0}};
                    state_d = START;
                end else begin
                    row_d = row_q + STATE_ADDR_WIDTH'(1);
                end
            end
            START: begin
                o_qea_start = 1'b1;
                cycle_d     = 32'd0;
                run_first_d = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                // completion is still stale from the previous job during the first RUN cycle
                run_first_d = 1'b0;
                if (!run_first_q && i_qea_complete) begin
                    row_d   = {STATE_ADDR_WIDTH{1'b0}};
                    state_d = RD_REQ;
                end else begin
                    cycle_d = (&cycle_q) ? cycle_q : cycle_q + 32'd1;
                end
            end
            RD_REQ: begin
                o_qea_state_ena   = 1'b1;
                o_qea_state_addra = row_q;
                state_d           = RD_WAIT;
            end
            RD_WAIT: begin
                res_data_d = i_qea_state_dout;
                state_d    = RD_OUT;
            end
            RD_OUT: begin
                o_res_valid = 1'b1;
                o_res_last  = last_hit_s;
                if (i_res_ready && last_hit_s) begin
                    state_d = IDLE;
                end else if (i_res_ready) begin
                    row_d   = row_q + STATE_ADDR_WIDTH'(1);
                    state_d = RD_REQ;
                end else begin
                    state_d = RD_OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            qbit_q      <= {MAX_QBIT_WIDTH{1'b0}};
            ins_q       <= {CW{1'b0}};
            ctx_cnt_q   <= {CW{1'b0}};
            last_row_q  <= {STATE_ADDR_WIDTH{1'b0}};
            row_q       <= {STATE_ADDR_WIDTH{1'b0}};
            run_first_q <= 1'b0;
            err_q       <= 1'b0;
            res_data_q  <= {PW{1'b0}};
        end else begin
            state_q     <= state_d;
            qbit_q      <= qbit_d;
            ins_q       <= ins_d;
            ctx_cnt_q   <= ctx_cnt_d;
            last_row_q  <= last_row_d;
            row_q       <= row_d;
            run_first_q <= run_first_d;
            err_q       <= err_d;
            res_data_q  <= res_data_d;
        end
    end

    // Cycle counter keeps the last job's figure across reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_q <= cycle_d;
        end
    end
endmodule

// File: tb/tb_qea_host_ctrl.sv
// Scoreboard bench for qea_host_ctrl: random jobs against a behavioural QEA
// and state-RAM model, with directed error, stall and reset scenarios.
module tb_qea_host_ctrl;
    localparam int PNW = 2, DW = 32, NFB = 30, MQW = 6, SAW = 16, CAW = 16;
    localparam int AW = 2 * DW, PW = (1 << PNW) * AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_cmd_valid, o_cmd_ready;
    logic [MQW-1:0]    i_cmd_qbit_num;
    logic [CAW:0]      i_cmd_ins_num;
    logic              i_ctx_valid, o_ctx_ready;
    logic [AW-1:0]     i_ctx_data;
    logic              o_res_valid, i_res_ready, o_res_last, o_err;
    logic [PW-1:0]     o_res_data;
    logic [31:0]       o_cycle_count;
    logic              o_qea_ctx_we;
    logic [CAW-1:0]    o_qea_ctx_addr;
    logic [AW-1:0]     o_qea_ctx_data;
    logic              o_qea_state_ena, o_qea_state_wea;
    logic [SAW-1:0]    o_qea_state_addra;
    logic [PW-1:0]     o_qea_state_dina;
    logic              o_qea_start;
    logic [MQW-1:0]    o_qea_qbit_num;
    logic              i_qea_complete;
    logic [PW-1:0]     i_qea_state_dout;

    always #5 clk = ~clk;

    qea_host_ctrl #(.PE_NUM_WIDTH(PNW), .DATA_WIDTH(DW), .NUM_FRAC_BIT(NFB),
                    .MAX_QBIT_WIDTH(MQW), .STATE_ADDR_WIDTH(SAW), .CTX_ADDR_WIDTH(CAW)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_qbit_num(i_cmd_qbit_num), .i_cmd_ins_num(i_cmd_ins_num),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_data(o_res_data), .o_res_last(o_res_last),
        .o_err(o_err), .o_cycle_count(o_cycle_count),
        .o_qea_ctx_we(o_qea_ctx_we), .o_qea_ctx_addr(o_qea_ctx_addr), .o_qea_ctx_data(o_qea_ctx_data),
        .o_qea_state_ena(o_qea_state_ena), .o_qea_state_wea(o_qea_state_wea),
        .o_qea_state_addra(o_qea_state_addra), .o_qea_state_dina(o_qea_state_dina),
        .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
        .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout)
    );

    typedef struct packed { logic [CAW-1:0] addr; logic [AW-1:0] data; } ctx_t;
    typedef struct packed { logic [SAW-1:0] addr; logic [PW-1:0] data; } sw_t;
    typedef struct packed { logic last; logic [PW-1:0] data; } res_t;
    ctx_t exp_ctx_q[$];
    sw_t  exp_sw_q[$];
    res_t exp_res_q[$];

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_ctx = 0, n_sw = 0, n_start = 0, n_rd = 0, n_err = 0;
    int s_ctx, s_sw, s_start, s_rd;
    int cur_n, cur_rows, qea_lat, exp_cc, rows_done, first_sw, hs_cyc, stall_n, rdy_mode;
    int qcnt;
    bit stale;
    logic [31:0] job_seed;
    logic [PW-1:0] init_row;
    logic [PW-1:0] mem [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got an unexpected event, required none", name);
    endtask

    function automatic logic [PW-1:0] scr(input int r);
        return {8{job_seed ^ (32'(r) * 32'h9E37_79B9)}};
    endfunction

    // Behavioural QEA: state RAM with 1-cycle read, completes qea_lat cycles after start
    always @(posedge clk) begin
        if (o_qea_state_ena && o_qea_state_wea) mem[o_qea_state_addra[5:0]] <= o_qea_state_dina;
        if (o_qea_state_ena && !o_qea_state_wea) i_qea_state_dout <= mem[o_qea_state_addra[5:0]];
        if (rst) begin
            qcnt <= 0;
            i_qea_complete <= 1'b0;
        end else if (o_qea_start && stale) begin
            qcnt <= 0;
            i_qea_complete <= 1'b1;
            for (int r = 0; r < cur_rows; r++) begin
                mem[r] <= mem[r] ^ scr(r);
                exp_res_q.push_back({(r == cur_rows - 1), mem[r] ^ scr(r)});
            end
        end else if (o_qea_start) begin
            qcnt <= qea_lat;
            i_qea_complete <= 1'b0;
        end else if (qcnt > 1) begin
            qcnt <= qcnt - 1;
        end else if (qcnt == 1) begin
            qcnt <= 0;
            i_qea_complete <= 1'b1;
            for (int r = 0; r < cur_rows; r++) begin
                mem[r] <= mem[r] ^ scr(r);
                exp_res_q.push_back({(r == cur_rows - 1), mem[r] ^ scr(r)});
            end
        end
    end

    // Monitor: pops the scoreboard queues whenever the DUT presents a transfer
    initial begin
        ctx_t ec;
        sw_t  es;
        res_t er;
        bit prev_stall;
        logic [PW-1:0] prev_data;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("res_hold_valid", o_res_valid, 1);
                    chk("res_hold_data", o_res_data, prev_data);
                end
                if (o_res_valid) begin
                    chk("no_read_while_pending", o_qea_state_ena, 0);
                    chk("cmd_ready_busy", o_cmd_ready, 0);
                end
                prev_stall = o_res_valid && !i_res_ready;
                prev_data  = o_res_data;
                if (o_qea_ctx_we) begin
                    n_ctx++;
                    if (exp_ctx_q.size() == 0) fail("ctx_write_unexpected");
                    else begin
                        ec = exp_ctx_q.pop_front();
                        chk("ctx_addr", o_qea_ctx_addr, ec.addr);
                        chk("ctx_data", o_qea_ctx_data, ec.data);
                    end
                end
                if (o_qea_state_ena && o_qea_state_wea) begin
                    n_sw++;
                    if (first_sw < 0) first_sw = cyc;
                    if (exp_sw_q.size() == 0) fail("state_write_unexpected");
                    else begin
                        es = exp_sw_q.pop_front();
                        chk("init_addr", o_qea_state_addra, es.addr);
                        chk("init_data", o_qea_state_dina, es.data);
                    end
                end
                if (o_qea_state_ena && !o_qea_state_wea) n_rd++;
                if (o_qea_start) begin
                    n_start++;
                    chk("qbit_num", o_qea_qbit_num, cur_n);
                end
                if (o_err) n_err++;
                if (o_res_valid && i_res_ready) begin
                    if (exp_res_q.size() == 0) fail("result_unexpected");
                    else begin
                        er = exp_res_q.pop_front();
                        chk("res_data", o_res_data, er.data);
                        chk("res_last", o_res_last, er.last);
                        if (er.last) chk("cycle_count", o_cycle_count, exp_cc);
                    end
                    rows_done++;
                end
            end
        end
    end

    // Result-ready driver: random, always-ready, or a 5-cycle stall on row 1
    initial begin
        i_res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) i_res_ready = 1'($urandom_range(0, 1));
            else if (rdy_mode == 2 && o_res_valid && rows_done == 1 && stall_n < 5) begin
                i_res_ready = 1'b0;
                stall_n++;
            end else i_res_ready = 1'b1;
        end
    end

    task automatic wait_cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int n, input int ins);
        int b = 0;
        while (!o_cmd_ready && b < 500) begin wait_cycles(1); b++; end
        chk("cmd_ready_wait", o_cmd_ready, 1);
        i_cmd_valid = 1'b1;
        i_cmd_qbit_num = MQW'(n);
        i_cmd_ins_num = (CAW+1)'(ins);
        @(negedge clk);
        hs_cyc = cyc;
        wait_cycles(1);
        i_cmd_valid = 1'b0;
        i_cmd_qbit_num = '0;
    endtask

    task automatic job_begin(input int n, input int ins, input int lat, input bit stl, input bit tog);
        int b;
        logic [AW-1:0] w;
        logic [AW-1:0] words[$];
        cur_n = n; cur_rows = 1 << (n - PNW); qea_lat = lat; stale = stl;
        exp_cc = stl ? 1 : lat;
        job_seed = $urandom; rows_done = 0; first_sw = -1; stall_n = 0;
        i_ctx_valid = 1'b1; i_ctx_data = {$urandom, $urandom};
        wait_cycles(2);
        i_ctx_valid = 1'b0;
        for (int k = 0; k < ins; k++) begin
            w = {$urandom, $urandom};
            words.push_back(w);
            exp_ctx_q.push_back({CAW'(k), w});
        end
        for (int r = 0; r < cur_rows; r++)
            exp_sw_q.push_back({SAW'(r), (r == 0) ? init_row : {PW{1'b0}}});
        s_ctx = n_ctx; s_sw = n_sw; s_start = n_start; s_rd = n_rd;
        send_cmd(n, ins);
        foreach (words[k]) begin
            wait_cycles(tog ? 1 : $urandom_range(0, 2));
            i_ctx_valid = 1'b1;
            i_ctx_data = words[k];
            b = 0;
            while (!o_ctx_ready && b < 50) begin wait_cycles(1); b++; end
            wait_cycles(1);
            i_ctx_valid = 1'b0;
            i_ctx_data = {$urandom, $urandom};
        end
        i_cmd_valid = 1'b1; i_cmd_qbit_num = MQW'(4); i_cmd_ins_num = '0;
        wait_cycles(3);
        i_cmd_valid = 1'b0;
    endtask

    task automatic job_end(input int ins);
        int b = 0;
        while (rows_done < cur_rows && b < 3000) begin wait_cycles(1); b++; end
        chk("job_rows_done", rows_done, cur_rows);
        wait_cycles(2);
        chk("ctx_writes", n_ctx - s_ctx, ins);
        chk("state_writes", n_sw - s_sw, cur_rows);
        chk("start_pulses", n_start - s_start, 1);
        chk("row_reads", n_rd - s_rd, cur_rows);
        chk("res_queue_empty", exp_res_q.size(), 0);
        chk("cmd_ready_idle", o_cmd_ready, 1);
        if (ins == 0) chk("init_directly_after_cmd", first_sw, hs_cyc + 1);
    endtask

    task automatic err_cmd(input int n);
        int e0, a0;
        e0 = n_err;
        a0 = n_ctx + n_sw + n_start + n_rd;
        send_cmd(n, $urandom_range(0, 5));
        wait_cycles(3);
        chk("err_pulse", n_err - e0, 1);
        chk("err_no_activity", n_ctx + n_sw + n_start + n_rd - a0, 0);
        chk("err_cmd_ready", o_cmd_ready, 1);
    endtask

    initial begin
        int b, a0, nn, ii;
        logic [31:0] cc0;
        init_row = '0;
        init_row[PW-1 -: 32] = 32'h4000_0000;
        rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_qbit_num = '0; i_cmd_ins_num = '0;
        i_ctx_valid = 1'b0; i_ctx_data = '0; rdy_mode = 1; cur_rows = 0; cur_n = 0; stale = 1'b0;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", o_cmd_ready, 1);
        chk("reset_res_valid", o_res_valid, 0);
        chk("reset_err", o_err, 0);
        chk("reset_res_data", o_res_data, 0);
        chk("reset_qbit_num", o_qea_qbit_num, 0);
        chk("reset_start", o_qea_start, 0);
        wait_cycles(1);

        job_begin(4, 3, 10, 1'b0, 1'b0);
        job_end(3);
        err_cmd(2);
        err_cmd(19);
        err_cmd(0);
        rdy_mode = 0;
        job_begin(5, 6, 7, 1'b0, 1'b1);
        job_end(6);
        rdy_mode = 2;
        job_begin(4, 2, 5, 1'b0, 1'b0);
        job_end(2);
        chk("stall_cycles", stall_n, 5);
        rdy_mode = 1;
        job_begin(3, 0, 3, 1'b0, 1'b0);
        job_end(0);
        job_begin(4, 1, 0, 1'b1, 1'b0);
        job_end(1);

        job_begin(5, 2, 40, 1'b0, 1'b0);
        b = 0;
        while (n_start == s_start && b < 200) begin wait_cycles(1); b++; end
        wait_cycles(5);
        cc0 = o_cycle_count;
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_run_cmd_ready", o_cmd_ready, 1);
        chk("rst_run_res_valid", o_res_valid, 0);
        chk("rst_run_state_ena", o_qea_state_ena, 0);
        chk("rst_run_qbit_num", o_qea_qbit_num, 0);
        chk("rst_run_cycle_hold", o_cycle_count, cc0);
        a0 = n_ctx + n_sw + n_start + n_rd;
        wait_cycles(6);
        chk("rst_quiet", n_ctx + n_sw + n_start + n_rd - a0, 0);
        exp_res_q.delete();
        job_begin(3, 2, 4, 1'b0, 1'b0);
        job_end(2);

        for (int j = 0; j < 6; j++) begin
            rdy_mode = 0;
            nn = $urandom_range(3, 6);
            ii = $urandom_range(0, 8);
            job_begin(nn, ii, $urandom_range(1, 20), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            job_end(ii);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
